prog_loader: RTL
================

# prog_loader

Byte-stream program loader for the MIPS core's instruction-memory programming port. It takes bytes from the serial receive path and assembles them into 32-bit instruction words. It writes each word through `Addr_Prog`/`Data_Prog` with `ProgMode` held at program (0), then releases the core into run mode with a controlled reset sequence. It sits between the UART receiver and the `MIPS` top, and replaces bench-driven programming in hardware.

## Interface
- `RELEASE_CYCLES`, 2: cycles `Core_reset` stays high after `ProgMode` goes to 1.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles between bytes while loading; the counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `reload` in 1: one-cycle request to re-enter load mode.
- `Addr_Prog` out 8: instruction-memory word address.
- `Data_Prog` out 32: instruction word.
- `Prog_We` out 1: one-cycle write strobe qualifying `Addr_Prog`/`Data_Prog`.
- `ProgMode` out 1: 0 = program (write), 1 = run.
- `Core_reset` out 1: drives the `MIPS` `reset`.
- `Busy` out 1: high in LOAD and RELEASE.
- `Done` out 1: high in RUN.
- `Err` out 1: sticky error flag.

## Operation
- **Frame format:** one count byte N (1..255 words), then 4·N bytes, MSB first per word. Words are written to addresses 0..N-1.
- **States:** IDLE, LOAD, RELEASE, RUN.
- **IDLE:**
  - `ProgMode`=0, `Core_reset`=1.
  - `rx_valid` with N≠0: latch N, clear `Err`, clear the address counter and byte index, go to LOAD.
  - N=0: set `Err`, stay in IDLE.
- **LOAD:**
  - Each accepted byte shifts into a 32-bit assembly register: `asm <= {asm[23:0], rx_data}`. The 2-bit byte index increments.
  - On the 4th byte (index 3): register `Data_Prog`=assembled word and `Addr_Prog`=word counter, and pulse `Prog_We`. Then increment the word counter (8-bit; N≤255, so no wrap).
  - After the write of word N-1, go to RELEASE.
- **Timeout:** the idle counter resets on every accepted byte. Reaching `TIMEOUT_CYCLES` in LOAD sets `Err`, discards the partial word and returns to IDLE. Words already written stay in memory.
- **RELEASE:** `ProgMode`=1 and `Core_reset`=1 for `RELEASE_CYCLES` cycles, then go to RUN.
- **RUN:**
  - `Core_reset`=0, `ProgMode`=1, `Done`=1.
  - `rx_valid` is ignored.
  - `reload` goes to IDLE: `Core_reset`=1 and `ProgMode`=0 in the next cycle.
- `reload` is ignored outside RUN.
- **Reset values:** `Addr_Prog`=0, `Data_Prog`=0, `Prog_We`=0, `ProgMode`=0, `Core_reset`=1, `Busy`=0, `Done`=0, `Err`=0; state IDLE.

## Timing
- All outputs are registered.
- Byte-to-write latency: `Prog_We` is high in the cycle after the 4th byte's `rx_valid`. Address and data are stable in that same cycle and hold until the next write.
- Back-to-back `rx_valid` (every cycle) is accepted without loss. The write cycle of word k overlaps acceptance of the first byte of word k+1.
- Last word:
  - `Prog_We` and the LOAD→RELEASE transition occur in the same cycle.
  - `ProgMode` rises in the first RELEASE cycle, i.e. one cycle after `Prog_We`.
  - `Core_reset` falls `RELEASE_CYCLES` cycles after `ProgMode` rises.
- Timeout: `Err` rises in the cycle the counter equals `TIMEOUT_CYCLES`, and the state is IDLE in the next cycle.
- `reset` in any cycle, including mid-word or mid-RELEASE, forces reset values on the next edge and aborts any pending write.

## Structure
- Shared package `prog_loader_pkg`:
  - state enum `{IDLE, LOAD, RELEASE, RUN}`;
  - constants `PROG_MODE_WRITE`=1'b0, `PROG_MODE_RUN`=1'b1;
  - `WORD_BYTES`=4.
- A single module with no sub-modules; the timeout and release counters are inline.

## Test plan
- Header 0x02, bytes 10 60 00 DE F8 00 00 04 → writes (0, 0x106000DE) and (1, 0xF8000004). `ProgMode` then rises, `Core_reset` falls 2 cycles later and `Done`=1.
- Same frame with `rx_valid` every cycle → both writes occur and no byte is lost.
- Header 0x00 → `Err`=1, state stays IDLE and `Prog_We` never pulses. A following header 0x01 clears `Err`.
- Header 0x01, bytes 06 00 → then silence for `TIMEOUT_CYCLES` → `Err`=1, IDLE, no write.
- In RUN, pulse `reload` → next cycle `Core_reset`=1, `ProgMode`=0, `Done`=0. A new frame reloads from address 0.
- Assert `reset` after 3 bytes of word 0 → all outputs return to reset values and no `Prog_We` occurs.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the byte-stream program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  localparam logic PROG_MODE_WRITE = 1'b0;
  localparam logic PROG_MODE_RUN   = 1'b1;
  localparam int   WORD_BYTES      = 4;

endpackage

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Assembles a count-prefixed byte stream into 32-bit words, writes
//               them to instruction memory, then releases the core into run mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int RELEASE_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload,
  output logic [7:0]  Addr_Prog,
  output logic [31:0] Data_Prog,
  output logic        Prog_We,
  output logic        ProgMode,
  output logic        Core_reset,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  localparam int                   c_TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int                   c_REL_W     = $clog2(RELEASE_CYCLES + 1);
  localparam logic [c_TO_W-1:0]    c_TO_MAX    = c_TO_W'(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0]    c_TO_PRE    = c_TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_TO_W-1:0]    c_TO_ONE    = c_TO_W'(1);
  localparam logic [c_REL_W-1:0]   c_REL_LAST  = c_REL_W'(RELEASE_CYCLES - 1);
  localparam logic [c_REL_W-1:0]   c_REL_ONE   = c_REL_W'(1);
  localparam logic [1:0]           c_LAST_BYTE = 2'(WORD_BYTES - 1);

  state_e              r_state,      w_state;
  logic [7:0]          r_count,      w_count;
  logic [7:0]          r_word_cnt,   w_word_cnt;
  logic [1:0]          r_byte_idx,   w_byte_idx;
  logic [23:0]         r_asm,        w_asm;
  logic [c_TO_W-1:0]   r_idle_cnt,   w_idle_cnt;
  logic [c_REL_W-1:0]  r_rel_cnt,    w_rel_cnt;
  logic [7:0]          r_addr_prog,  w_addr_prog;
  logic [31:0]         r_data_prog,  w_data_prog;
  logic                r_prog_we,    w_prog_we;
  logic                r_prog_mode,  w_prog_mode;
  logic                r_core_reset, w_core_reset;
  logic                r_busy,       w_busy;
  logic                r_done,       w_done;
  logic                r_err,        w_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_count      <= 8'd0;
      r_word_cnt   <= 8'd0;
      r_byte_idx   <= 2'd0;
      r_asm        <= 24'd0;
      r_idle_cnt   <= '0;
      r_rel_cnt    <= '0;
      r_addr_prog  <= 8'd0;
      r_data_prog  <= 32'd0;
      r_prog_we    <= 1'b0;
      r_prog_mode  <= PROG_MODE_WRITE;
      r_core_reset <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_count      <= w_count;
      r_word_cnt   <= w_word_cnt;
      r_byte_idx   <= w_byte_idx;
      r_asm        <= w_asm;
      r_idle_cnt   <= w_idle_cnt;
      r_rel_cnt    <= w_rel_cnt;
      r_addr_prog  <= w_addr_prog;
      r_data_prog  <= w_data_prog;
      r_prog_we    <= w_prog_we;
      r_prog_mode  <= w_prog_mode;
      r_core_reset <= w_core_reset;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_count     = r_count;
    w_word_cnt  = r_word_cnt;
    w_byte_idx  = r_byte_idx;
    w_asm       = r_asm;
    w_idle_cnt  = r_idle_cnt;
    w_rel_cnt   = r_rel_cnt;
    w_addr_prog = r_addr_prog;
    w_data_prog = r_data_prog;
    w_prog_we   = 1'b0;
    w_err       = r_err;

    case (r_state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data != 8'd0) begin
            w_count    = rx_data;
            w_err      = 1'b0;
            w_word_cnt = 8'd0;
            w_byte_idx = 2'd0;
            w_idle_cnt = '0;
            w_state    = LOAD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      LOAD: begin
        // Word counter reaches N only in the cycle the last write is on the bus.
        if (r_word_cnt == r_count) begin
          w_rel_cnt = '0;
          w_state   = RELEASE;
        end else if (r_idle_cnt == c_TO_MAX) begin
          w_state = IDLE;
        end else if (rx_valid) begin
          w_asm      = {r_asm[15:0], rx_data};
          w_byte_idx = r_byte_idx + 2'd1;
          w_idle_cnt = '0;
          if (r_byte_idx == c_LAST_BYTE) begin
            w_data_prog = {r_asm, rx_data};
            w_addr_prog = r_word_cnt;
            w_prog_we   = 1'b1;
            w_word_cnt  = r_word_cnt + 8'd1;
          end
        end else begin
          w_idle_cnt = r_idle_cnt + c_TO_ONE;
          if (r_idle_cnt == c_TO_PRE) begin
            w_err = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (r_rel_cnt == c_REL_LAST) begin
          w_state = RUN;
        end else begin
          w_rel_cnt = r_rel_cnt + c_REL_ONE;
        end
      end
      RUN: begin
        if (reload) begin
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase

    // Mode outputs follow the upcoming state so they change on the transition edge.
    w_prog_mode  = (w_state == RELEASE || w_state == RUN) ? PROG_MODE_RUN : PROG_MODE_WRITE;
    w_core_reset = (w_state != RUN);
    w_busy       = (w_state == LOAD || w_state == RELEASE);
    w_done       = (w_state == RUN);
  end

  assign Addr_Prog  = r_addr_prog;
  assign Data_Prog  = r_data_prog;
  assign Prog_We    = r_prog_we;
  assign ProgMode   = r_prog_mode;
  assign Core_reset = r_core_reset;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Err        = r_err;

endmodule

`default_nettype wire
